// File: rtl/multdiv_issue_ctrl.sv
// Issue sequencer between execute and the iterative multdiv unit: latch, pulse, stall, write back.
// Optional WAIT timeout watchdog is compiled in with `define MULTDIV_TIMEOUT_EN.
module multdiv_issue_ctrl #(
  parameter int WIDTH         = 32,
  parameter int RADDR         = 5,
  parameter int RSTATUS_REG   = 30,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5
`ifdef MULTDIV_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TIMEOUT_CODE   = 6
`endif
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [RADDR-1:0] rd,
  input  logic             flush,
  output logic [WIDTH-1:0] md_operandA,
  output logic [WIDTH-1:0] md_operandB,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_ready,
  output logic             stall,
  output logic             wb_valid,
  output logic [RADDR-1:0] wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic             div_q, div_d;
  logic             wb_valid_q, wb_valid_d;
  logic [RADDR-1:0] wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             start_any;

  assign start_any = start_mult | start_div;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             tmo_hit;

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rd_d       = rd_q;
    div_d      = div_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
`ifdef MULTDIV_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_any) begin
          opa_d   = opA;
          opb_d   = opB;
          rd_d    = rd;
          div_d   = ~start_mult;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A ready seen here belongs to the previous operation.
        state_d = flush ? S_IDLE : S_WAIT;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (md_ready) begin
          state_d = S_DONE;
          if (md_exception) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = RADDR'(RSTATUS_REG);
            wb_data_d  = div_q ? WIDTH'(DIV_EXC_CODE) : WIDTH'(MULT_EXC_CODE);
          end else if (rd_q != '0) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = md_result;
          end
`ifdef MULTDIV_TIMEOUT_EN
        end else if (tmo_hit) begin
          state_d    = S_DONE;
          wb_valid_d = 1'b1;
          wb_rd_d    = RADDR'(RSTATUS_REG);
          wb_data_d  = WIDTH'(TIMEOUT_CODE);
          tmo_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      rd_q       <= '0;
      div_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      rd_q       <= rd_d;
      div_q      <= div_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Stall is combinational so execute freezes in the very cycle the op arrives.
  assign stall = ((state_q == S_IDLE) & start_any) |
                 (((state_q == S_ISSUE) | (state_q == S_WAIT)) & ~flush);

  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign md_ctrl_mult = (state_q == S_ISSUE) & ~div_q;
  assign md_ctrl_div  = (state_q == S_ISSUE) &  div_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;

`ifdef MULTDIV_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
